io_led_pwm: RTL
===============

Name: io_led_pwm

Overview:
- Downstream stage of the LED output register. Consumes its 3-bit `rgb_led` value and drives the physical RGB pins.
- Per-channel 8-bit PWM brightness, global prescaler, enable and polarity control.
- Its own registers sit on the DMA IO bus, in the read-data daisy chain directly after the LED register block.

Parameters:
- CNT_W, 8, PWM counter/duty width (frame = 2^CNT_W ticks)
- PRE_W, 8, prescaler width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- dma_io_we  in  1  IO bus write strobe
- dma_io_wadr  in  [15:2]  IO bus write word address
- dma_io_wdata  in  16  IO bus write data
- dma_io_radr  in  [15:2]  IO bus read word address
- dma_io_rdata_in  in  16  read data from upstream chain member
- dma_io_rdata  out  16  read data to next chain member
- led_in  in  3  LED on/off value from LED register block ({B,G,R} = [2:0])
- led_out  out  3  PWM-modulated pin drive

Behaviour:
- Reset is synchronous: on posedge clk with rst_n=0, all registers and counters clear to 0. led_out=0 one cycle later. Reset mid-frame simply restarts the frame.
- Register map (word addr):
  - 0x3F81 PWM_RG: [7:0] duty_r, [15:8] duty_g
  - 0x3F82 PWM_B: [7:0] duty_b, [15:8] presc
  - 0x3F83 CTRL: [0] en, [1] inv, [15:8] blink_len (feature only); other bits read 0
- Writes take effect on the clock edge where dma_io_we=1 and dma_io_wadr matches.
- Reads are combinational:
  - dma_io_rdata = selected register when dma_io_radr matches one of the three addresses;
  - otherwise dma_io_rdata = dma_io_rdata_in.
  - A read of a register in the same cycle as a write to it returns the old value.
- Prescaler:
  - pre_cnt counts 0..presc, then returns to 0.
  - tick=1 in the cycle where pre_cnt==presc.
  - presc=0 gives tick every cycle.
  - A presc write mid-count that lands below pre_cnt: pre_cnt continues to 2^PRE_W-1, wraps to 0, then restarts the 0..presc count (no lockup).
- PWM counter: pwm_cnt increments on tick and wraps 255→0. The wrap marks frame start.
- Shadowing: duty_r/g/b are copied to active duties only at frame start, i.e. the tick that wraps pwm_cnt to 0. This is glitch-free. After reset, the shadows are 0.
- Channel output: on_i = led_in[i] & (pwm_cnt < active_duty_i).
  - duty 0 → always off;
  - duty 255 → on 255 of 256 ticks.
- en=0: PWM bypassed, on_i = led_in[i]. Counters keep running.
- led_out[i] = register(on_i ^ inv). One-cycle latency from led_in / pwm_cnt to pins.
- Simultaneous register write and frame start: the write updates the user register. The shadow loads the pre-write value; the new value applies from the next frame.

Optional Feature:
- Macro: LED_PWM_BLINK_EN.
- With macro defined:
  - CTRL[15:8] = blink_len is implemented.
  - An 8-bit frame counter advances at each frame start. When it reaches blink_len it clears and toggles blink_phase.
  - blink_phase=0 forces on_i=0 before the inv XOR.
  - blink_len=0 → blink disabled, blink_phase held at 1.
  - Writing blink_len clears the frame counter and sets blink_phase=1.
- Without macro: CTRL[15:8] reads 0, writes to it are ignored, and there is no blink logic.

Decomposition:
- Shared package io_led_pkg holds:
  - address constants LED_PWM_RG_ADR=14'h3F81, LED_PWM_B_ADR=14'h3F82, LED_PWM_CTRL_ADR=14'h3F83, alongside the existing LED value address 14'h3F80;
  - CTRL bit indices;
  - CNT_W/PRE_W defaults.
- One sub-module is natural: led_pwm_chan (shadow duty register + compare + inv/output flop), instantiated 3 times.
- The prescaler and frame counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with nonzero bus write attempts → all registers read 0, led_out=0, dma_io_rdata passes rdata_in (0xA5A5) for radr=0x3F80.
- Bypass: en=0, inv=0, led_in=3'b101 → led_out=3'b101 one cycle later. Set inv=1 → 3'b010.
- PWM duty: en=1, presc=0, duty_r=64, led_in=3'b001 → over a 256-cycle frame led_out[0] high exactly 64 cycles from frame start. duty_r=0 → never high.
- Shadowing: write duty_g=200 mid-frame (pwm_cnt=100) → current frame keeps the old duty; new duty applies from the next frame. Write coincident with frame start → applies one frame later.
- Prescaler: presc=3, duty_b=2 → tick every 4 clk, led_out[2] high 8 cycles per 1024-cycle frame. Write presc=1 while pre_cnt=3 → counter wraps through 255, no hang.
- Blink (LED_PWM_BLINK_EN): blink_len=2, presc=0, duty=255 → output alternates 3 frames on / 3 frames off. Without the macro, CTRL reads 0x0001 after writing 0x0201.

Source files
------------

// File: rtl/io_led_pkg.sv
// Shared constants for the LED IO block: bus word addresses, CTRL bit positions
// and default counter widths for the PWM stage.
package io_led_pkg;

    localparam int LED_CNT_W = 8;
    localparam int LED_PRE_W = 8;

    // LED_VAL_ADR belongs to the upstream LED register block; the PWM stage follows it.
    localparam logic [13:0] LED_VAL_ADR      = 14'h3F80;
    localparam logic [13:0] LED_PWM_RG_ADR   = 14'h3F81;
    localparam logic [13:0] LED_PWM_B_ADR    = 14'h3F82;
    localparam logic [13:0] LED_PWM_CTRL_ADR = 14'h3F83;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_INV_BIT  = 1;
    localparam int CTRL_BLEN_LSB = 8;

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM output channel: frame-synchronous duty shadow, compare against the
// shared PWM counter, bypass/blink gating and the registered, polarity-adjusted pin.
module led_pwm_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [CNT_W-1:0] pwm_cnt_i,
    input  logic             led_i,
    input  logic             en_i,
    input  logic             inv_i,
    input  logic             gate_i,
    output logic             pin_o
);

    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] active_d;
    logic             pin_q;
    logic             pin_d;
    logic             pwm_on;

    // The shadow only moves on the tick that wraps the counter, so a frame never mixes duties.
    always_comb begin
        active_d = active_q;
        if (frame_start_i) begin
            active_d = duty_i;
        end
    end

    always_comb begin
        pwm_on = 1'b1;
        if (en_i) begin
            pwm_on = (pwm_cnt_i < active_q);
        end
        pin_d = (led_i & pwm_on & gate_i) ^ inv_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= '0;
            pin_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pin_q    <= pin_d;
        end
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/io_led_pwm.sv
// RGB LED PWM stage with bus-mapped duty/prescaler/control registers in the read chain.
// Optional blink gating is compiled in when LED_PWM_BLINK_EN is defined.
module io_led_pwm
    import io_led_pkg::*;
#(
    parameter int CNT_W = LED_CNT_W,
    parameter int PRE_W = LED_PRE_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [15:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic [15:0] dma_io_rdata_in,
    output logic [15:0] dma_io_rdata,
    input  logic [2:0]  led_in,
    output logic [2:0]  led_out
);

    logic [2:0][CNT_W-1:0] duty_q;
    logic [PRE_W-1:0]      presc_q;
    logic                  en_q;
    logic                  inv_q;

    logic [PRE_W-1:0]      pre_cnt_q;
    logic [PRE_W-1:0]      pre_cnt_d;
    logic [CNT_W-1:0]      pwm_cnt_q;
    logic [CNT_W-1:0]      pwm_cnt_d;

    logic                  tick;
    logic                  frame_start;
    logic                  we_rg;
    logic                  we_b;
    logic                  we_ctrl;
    logic                  blink_gate;
    logic [7:0]            blink_len_rd;
    logic [15:0]           ctrl_rd;

    assign we_rg   = dma_io_we && (dma_io_wadr == LED_PWM_RG_ADR);
    assign we_b    = dma_io_we && (dma_io_wadr == LED_PWM_B_ADR);
    assign we_ctrl = dma_io_we && (dma_io_wadr == LED_PWM_CTRL_ADR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q  <= '0;
            presc_q <= '0;
            en_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            if (we_rg) begin
                duty_q[0] <= dma_io_wdata[CNT_W-1:0];
                duty_q[1] <= dma_io_wdata[8 +: CNT_W];
            end
            if (we_b) begin
                duty_q[2] <= dma_io_wdata[CNT_W-1:0];
                presc_q   <= dma_io_wdata[8 +: PRE_W];
            end
            if (we_ctrl) begin
                en_q  <= dma_io_wdata[CTRL_EN_BIT];
                inv_q <= dma_io_wdata[CTRL_INV_BIT];
            end
        end
    end

    // A prescaler lowered below the running count free-runs to the natural wrap, never locks up.
    always_comb begin
        tick        = (pre_cnt_q == presc_q);
        frame_start = tick && (pwm_cnt_q == {CNT_W{1'b1}});
        pre_cnt_d   = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef LED_PWM_BLINK_EN
    logic [7:0] blink_len_q;
    logic [7:0] frame_cnt_q;
    logic       blink_phase_q;

    // A CTRL write restarts the blink pattern in its on phase, even if it lands on a frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_len_q   <= 8'd0;
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (we_ctrl) begin
            blink_len_q   <= dma_io_wdata[CTRL_BLEN_LSB +: 8];
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b1;
        end else if (frame_start && (blink_len_q != 8'd0)) begin
            if (frame_cnt_q == blink_len_q) begin
                frame_cnt_q   <= 8'd0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q   <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign blink_gate   = (blink_len_q == 8'd0) || blink_phase_q;
    assign blink_len_rd = blink_len_q;
`else
    assign blink_gate   = 1'b1;
    assign blink_len_rd = 8'd0;
`endif

    always_comb begin
        ctrl_rd                         = '0;
        ctrl_rd[CTRL_EN_BIT]            = en_q;
        ctrl_rd[CTRL_INV_BIT]           = inv_q;
        ctrl_rd[CTRL_BLEN_LSB +: 8]     = blink_len_rd;
    end

    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        case (dma_io_radr)
            LED_PWM_RG_ADR:   dma_io_rdata = {duty_q[1], duty_q[0]};
            LED_PWM_B_ADR:    dma_io_rdata = {presc_q, duty_q[2]};
            LED_PWM_CTRL_ADR: dma_io_rdata = ctrl_rd;
            default:          dma_io_rdata = dma_io_rdata_in;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        led_pwm_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .frame_start_i (frame_start),
            .duty_i        (duty_q[i]),
            .pwm_cnt_i     (pwm_cnt_q),
            .led_i         (led_in[i]),
            .en_i          (en_q),
            .inv_i         (inv_q),
            .gate_i        (blink_gate),
            .pin_o         (led_out[i])
        );
    end

endmodule
